// File: rtl/mont_modexp_ctrl.sv
// mont_modexp_ctrl
//   Left-to-right square-and-multiply sequencer for modular exponentiation in
//   the Montgomery domain. Drives an external Montgomery multiplier with
//   one-cycle start pulses and chains its results into base^exp * R mod m.
//   Operands enter and leave already in Montgomery form.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   start_p           : one-cycle start request (honoured only in IDLE)
//   base_m, one_m     : base*R mod m, R mod m
//   exponent,exp_bits : exponent and number of its low bits to process
//   m, m_size         : modulus and multiplier size, latched at start
//   mul_*             : multiplier request (enable/a/b/m/m_size) and response (y/done)
//   result            : base^exp*R mod m, updated on entry to DONE
//   busy, done_irq_p  : not-IDLE flag, one-cycle completion pulse
module mont_modexp_ctrl #(
    parameter int NBITS     = 2048,
    parameter int LOG2NBITS = $clog2(NBITS),
    parameter int EBITS     = 2048,
    parameter int LOG2EBITS = $clog2(EBITS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_p,
    input  logic [NBITS-1:0]     base_m,
    input  logic [NBITS-1:0]     one_m,
    input  logic [EBITS-1:0]     exponent,
    input  logic [LOG2EBITS:0]   exp_bits,
    input  logic [NBITS-1:0]     m,
    input  logic [LOG2NBITS:0]   m_size,
    output logic                 mul_enable_p,
    output logic [NBITS-1:0]     mul_a,
    output logic [NBITS-1:0]     mul_b,
    output logic [NBITS-1:0]     mul_m,
    output logic [LOG2NBITS:0]   mul_m_size,
    input  logic [NBITS-1:0]     mul_y,
    input  logic                 mul_done_p,
    output logic [NBITS-1:0]     result,
    output logic                 busy,
    output logic                 done_irq_p
);

    typedef enum logic [2:0] {
        IDLE, SQR_ISSUE, SQR_WAIT, MUL_ISSUE, MUL_WAIT, DONE
    } state_t;

    state_t                 state, state_nx;
    logic [NBITS-1:0]       acc, acc_nx;
    logic [NBITS-1:0]       base_reg, m_reg;
    logic [EBITS-1:0]       exp_reg;
    logic [LOG2NBITS:0]     msize_reg;
    logic [LOG2EBITS-1:0]   bit_idx, bit_idx_nx;
    logic                   accept;

    always_comb begin
        state_nx   = state;
        acc_nx     = acc;
        bit_idx_nx = bit_idx;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start_p) begin
                    accept     = 1'b1;
                    acc_nx     = one_m;
                    // Wraps harmlessly when exp_bits==0: DONE never reads it.
                    bit_idx_nx = LOG2EBITS'(exp_bits - 1'b1);
                    state_nx   = (exp_bits == '0) ? DONE : SQR_ISSUE;
                end
            end
            SQR_ISSUE: state_nx = SQR_WAIT;
            SQR_WAIT: begin
                if (mul_done_p) begin
                    acc_nx = mul_y;
                    if (exp_reg[bit_idx]) begin
                        state_nx = MUL_ISSUE;
                    end else if (bit_idx == '0) begin
                        state_nx = DONE;
                    end else begin
                        bit_idx_nx = bit_idx - 1'b1;
                        state_nx   = SQR_ISSUE;
                    end
                end
            end
            MUL_ISSUE: state_nx = MUL_WAIT;
            MUL_WAIT: begin
                if (mul_done_p) begin
                    acc_nx = mul_y;
                    if (bit_idx == '0) begin
                        state_nx = DONE;
                    end else begin
                        bit_idx_nx = bit_idx - 1'b1;
                        state_nx   = SQR_ISSUE;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            bit_idx   <= '0;
            base_reg  <= '0;
            exp_reg   <= '0;
            m_reg     <= '0;
            msize_reg <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            result    <= '0;
        end else begin
            state   <= state_nx;
            acc     <= acc_nx;
            bit_idx <= bit_idx_nx;
            if (accept) begin
                base_reg  <= base_m;
                exp_reg   <= exponent;
                m_reg     <= m;
                msize_reg <= m_size;
            end
            // Operands load on entry to an ISSUE state and then hold through
            // the matching WAIT, so the multiplier may sample them any time.
            if (state_nx == SQR_ISSUE) begin
                mul_a <= acc_nx;
                mul_b <= acc_nx;
            end else if (state_nx == MUL_ISSUE) begin
                mul_a <= acc_nx;
                mul_b <= base_reg;
            end
            if (state_nx == DONE) result <= acc_nx;
        end
    end

    assign mul_enable_p = (state == SQR_ISSUE) || (state == MUL_ISSUE);
    assign mul_m        = m_reg;
    assign mul_m_size   = msize_reg;
    assign busy         = (state != IDLE);
    assign done_irq_p   = (state == DONE);

endmodule

// File: doc/mont_modexp_ctrl.md
# mont_modexp_ctrl

Left-to-right square-and-multiply sequencer that computes a modular exponentiation entirely in the Montgomery domain. It sits directly downstream of the bit-serial Montgomery multiplier `montgomery_mul` and drives that multiplier. It issues one-cycle `enable_p` pulses with operands, consumes the `y` / `done_irq_p` results, and chains them into a full `base^exp` operation. Domain conversion into and out of Montgomery form is done outside this block.

## Interface
- `NBITS`, default 2048: operand and modulus width; must match the attached multiplier.
- `LOG2NBITS`, default `$clog2(NBITS)`: width base for `m_size`.
- `EBITS`, default 2048: exponent register width.
- `LOG2EBITS`, default `$clog2(EBITS)`: width base for `exp_bits`.

Ports:
- `clk` in, 1 bit: single clock.
- `rst` in, 1 bit: synchronous, active-high reset.
- `start_p` in, 1 bit: one-cycle start request.
- `base_m` in, NBITS: base in Montgomery form (`base·R mod m`).
- `one_m` in, NBITS: `R mod m`.
- `exponent` in, EBITS: exponent value.
- `exp_bits` in, LOG2EBITS+1: number of exponent bits to process, from bit `exp_bits-1` down to 0.
- `m` in, NBITS: modulus.
- `m_size` in, LOG2NBITS+1: forwarded to the multiplier.
- `mul_enable_p` out, 1 bit: start pulse to the multiplier.
- `mul_a` out, NBITS: multiplier operand a.
- `mul_b` out, NBITS: multiplier operand b.
- `mul_m` out, NBITS: multiplier modulus.
- `mul_m_size` out, LOG2NBITS+1: multiplier size.
- `mul_y` in, NBITS: multiplier result.
- `mul_done_p` in, 1 bit: multiplier completion pulse.
- `result` out, NBITS: `base^exp·R mod m`; valid from `done_irq_p` until the next accepted start.
- `busy` out, 1 bit: high in every state except IDLE.
- `done_irq_p` out, 1 bit: one-cycle completion pulse.

## Operation
- **States:** IDLE, SQR_ISSUE, SQR_WAIT, MUL_ISSUE, MUL_WAIT, DONE.
- **IDLE:**
  - `start_p=1` latches `base_m`, `exponent`, `m` and `m_size` into internal registers.
  - It sets `acc=one_m` and `bit_idx=exp_bits-1`.
  - It moves to SQR_ISSUE, or to DONE if `exp_bits==0`.
  - `start_p` in any state other than IDLE is ignored; no relatch.
- **SQR_ISSUE:** `mul_enable_p=1` for exactly this cycle, with `mul_a=mul_b=acc`. Next state SQR_WAIT.
- **SQR_WAIT:** on `mul_done_p=1`, `acc<=mul_y`.
  - If `exp_reg[bit_idx]==1`, go to MUL_ISSUE.
  - Otherwise go to DONE if `bit_idx==0`, else decrement `bit_idx` and go to SQR_ISSUE.
- **MUL_ISSUE:** `mul_enable_p=1` for exactly this cycle, with `mul_a=acc`, `mul_b=base_reg`. Next state MUL_WAIT.
- **MUL_WAIT:** on `mul_done_p=1`, `acc<=mul_y`. Then go to DONE if `bit_idx==0`, else decrement `bit_idx` and go to SQR_ISSUE.
- **DONE:** `done_irq_p=1` for this cycle only, `result=acc`. Next state IDLE.
- `result` is a register; it updates only on entry to DONE.
- `mul_done_p` outside SQR_WAIT/MUL_WAIT is ignored.
- `mul_a` and `mul_b` are registered and held stable from the ISSUE cycle through WAIT.
- `mul_m` and `mul_m_size` are driven from the latched registers, stable for the whole operation.
- Exponent bits at or above `exp_bits` are never examined.
- `exp_bits > EBITS` is illegal; no check is made.
- Leading zero bits are processed normally; squaring `one_m` stays `one_m`, so the result is unaffected. No skipping is done, so latency depends only on `exp_bits` and popcount.

## Timing
- **Reset values** (all outputs zero): state IDLE, `busy=0`, `done_irq_p=0`, `mul_enable_p=0`, `mul_a=mul_b=mul_m=0`, `mul_m_size=0`, `result=0`.
- **Reset mid-operation:** returns to IDLE on the next edge and clears `mul_enable_p`. A multiplier still running is not aborted; its later `mul_done_p` is ignored.
- **Multiplier latency L:** cycles from the `mul_enable_p` cycle to the `mul_done_p` cycle. Each multiplication costs L+1 cycles (ISSUE plus WAIT).
- **Start timing:** with `start_p` sampled in cycle s, SQR_ISSUE is in cycle s+1.
- **Completion:** `done_irq_p` is in cycle s+1+N·(L+1), where N = `exp_bits` + popcount(`exponent[exp_bits-1:0]`).
- **`exp_bits==0`:** `done_irq_p` is in cycle s+1 with `result=one_m`.
- **Back-to-back:** `start_p` in the DONE cycle is ignored. It is accepted from the following IDLE cycle.

## Test plan
- **Basic exponentiation.** Setup: NBITS=16, EBITS=16, `m=13`, R=16, behavioural multiplier `x·y·16⁻¹ mod 13` with L=5; `one_m=3`, `base_m=6` (base 2), `exponent=10`, `exp_bits=4`. Required: 6 `mul_enable_p` pulses; `done_irq_p` at s+37; `result=4` (2^10 mod 13 = 10, Montgomery form 4).
- **Zero bits processed.** `exponent=0`, `exp_bits=4`, same setup. Required: 4 squarings only; `done_irq_p` at s+25; `result=3`.
- **Empty exponent.** `exp_bits=0`. Required: no `mul_enable_p`; `done_irq_p` at s+1; `result=one_m=3`.
- **Start and done ignored outside their states.**
  - Pulse `start_p` with `base_m=9` while in SQR_WAIT: the operation continues with `base_m=6`, `result=4`.
  - Inject a spurious `mul_done_p` in SQR_ISSUE: it is ignored, and `acc` is unchanged.
- **Reset mid-operation.** Assert `rst` during MUL_WAIT. Required: next cycle all outputs 0 and state IDLE. A stale `mul_done_p` 3 cycles later causes no `done_irq_p`. A fresh start then yields `result=4`.
- **Integration with the real multiplier.** Setup: real `montgomery_mul`, NBITS=16, `m=13`, `m_size=4`. Required: `result` equals the software model of `base^exp·2^4 mod 13` for 50 random `base`/`exponent` pairs. Each `done_irq_p` is a single-cycle pulse.
